// File: rtl/read_router_pkg.sv
// Shared types and constants for the AXI read-data return path.
// Holds the router FSM encoding, default master tags and slave indices.
package read_router_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOCK_S0 = 2'd1,
        LOCK_S1 = 2'd2
    } rd_state_t;

    localparam int AXI_IDS_BITS  = 8;
    localparam int AXI_ID_BITS   = 4;
    localparam int AXI_DATA_BITS = 32;

    localparam logic [3:0] MASTER_TAG_M0_DEFAULT = 4'd0;
    localparam logic [3:0] MASTER_TAG_M1_DEFAULT = 4'd1;

    localparam logic SLAVE_S0 = 1'b0;
    localparam logic SLAVE_S1 = 1'b1;

    function automatic rd_state_t lock_state(input logic slave_idx);
        return (slave_idx == SLAVE_S1) ? LOCK_S1 : LOCK_S0;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter; ptr names the requester that wins a tie
// and moves past the winner whenever the owner reports a completed burst.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       upd_winner,
    output logic       gnt_valid,
    output logic       gnt_idx,
    output logic       ptr
);

    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (update) begin
            ptr <= ~upd_winner;
        end
    end

    always_comb begin
        gnt_valid = |req;
        unique case (req)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = ptr;
            default: gnt_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/read_data_router.sv
// Routes R-channel beats from slaves S0/S1 to masters M0/M1 by RID tag,
// locking the path to one slave until its RLAST beat completes.
module read_data_router
    import read_router_pkg::*;
#(
    parameter logic [3:0] MASTER_TAG_M0 = MASTER_TAG_M0_DEFAULT,
    parameter logic [3:0] MASTER_TAG_M1 = MASTER_TAG_M1_DEFAULT
) (
    input  logic        ACLK,
    input  logic        ARESET,

    input  logic [7:0]  RID_S0,
    input  logic [31:0] RDATA_S0,
    input  logic [1:0]  RRESP_S0,
    input  logic        RLAST_S0,
    input  logic        RVALID_S0,
    output logic        RREADY_S0,

    input  logic [7:0]  RID_S1,
    input  logic [31:0] RDATA_S1,
    input  logic [1:0]  RRESP_S1,
    input  logic        RLAST_S1,
    input  logic        RVALID_S1,
    output logic        RREADY_S1,

    output logic [3:0]  RID_M0,
    output logic [31:0] RDATA_M0,
    output logic [1:0]  RRESP_M0,
    output logic        RLAST_M0,
    output logic        RVALID_M0,
    input  logic        RREADY_M0,

    output logic [3:0]  RID_M1,
    output logic [31:0] RDATA_M1,
    output logic [1:0]  RRESP_M1,
    output logic        RLAST_M1,
    output logic        RVALID_M1,
    input  logic        RREADY_M1
);

    rd_state_t   state;
    rd_state_t   state_next;

    logic        arb_gnt_valid;
    logic        arb_gnt_idx;
    logic        arb_ptr;

    logic        gnt_valid;
    logic        gnt_idx;
    logic [7:0]  sel_rid;
    logic [31:0] sel_data;
    logic [1:0]  sel_resp;
    logic        sel_last;
    logic        sel_valid;
    logic        to_m0;
    logic        to_m1;
    logic        sel_ready;
    logic        handshake;

    rr_arb2 u_arb (
        .clk        (ACLK),
        .rst        (ARESET),
        .req        ({RVALID_S1, RVALID_S0}),
        .update     (handshake & sel_last),
        .upd_winner (gnt_idx),
        .gnt_valid  (arb_gnt_valid),
        .gnt_idx    (arb_gnt_idx),
        .ptr        (arb_ptr)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A locked slave keeps the grant even while its RVALID is low between beats.
    always_comb begin
        unique case (state)
            LOCK_S0: begin gnt_valid = 1'b1; gnt_idx = SLAVE_S0; end
            LOCK_S1: begin gnt_valid = 1'b1; gnt_idx = SLAVE_S1; end
            default: begin gnt_valid = arb_gnt_valid; gnt_idx = arb_gnt_idx; end
        endcase
    end

    assign sel_rid   = (gnt_idx == SLAVE_S1) ? RID_S1    : RID_S0;
    assign sel_data  = (gnt_idx == SLAVE_S1) ? RDATA_S1  : RDATA_S0;
    assign sel_resp  = (gnt_idx == SLAVE_S1) ? RRESP_S1  : RRESP_S0;
    assign sel_last  = (gnt_idx == SLAVE_S1) ? RLAST_S1  : RLAST_S0;
    assign sel_valid = (gnt_idx == SLAVE_S1) ? RVALID_S1 : RVALID_S0;

    assign to_m0 = (sel_rid[7:4] == MASTER_TAG_M0);
    assign to_m1 = !to_m0 && (sel_rid[7:4] == MASTER_TAG_M1);

    // Beats carrying an unknown tag are sunk so a stray ID cannot wedge the path.
    assign sel_ready = to_m0 ? RREADY_M0 : (to_m1 ? RREADY_M1 : 1'b1);
    assign handshake = !ARESET && gnt_valid && sel_valid && sel_ready;

    // NOTE: every output is given a default before the conditional drive, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        RREADY_S0 = 1'b0;
        RREADY_S1 = 1'b0;
        RID_M0    = '0;
        RDATA_M0  = '0;
        RRESP_M0  = '0;
        RLAST_M0  = 1'b0;
        RVALID_M0 = 1'b0;
        RID_M1    = '0;
        RDATA_M1  = '0;
        RRESP_M1  = '0;
        RLAST_M1  = 1'b0;
        RVALID_M1 = 1'b0;

        if (!ARESET && gnt_valid) begin
            if (gnt_idx == SLAVE_S1) begin
                RREADY_S1 = sel_ready;
            end else begin
                RREADY_S0 = sel_ready;
            end

            if (to_m0) begin
                RID_M0    = sel_rid[3:0];
                RDATA_M0  = sel_data;
                RRESP_M0  = sel_resp;
                RLAST_M0  = sel_last;
                RVALID_M0 = sel_valid;
            end else if (to_m1) begin
                RID_M1    = sel_rid[3:0];
                RDATA_M1  = sel_data;
                RRESP_M1  = sel_resp;
                RLAST_M1  = sel_last;
                RVALID_M1 = sel_valid;
            end
        end
    end

    // A granted slave locks unless it finishes a single-beat burst at once.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (gnt_valid && !(handshake && sel_last)) begin
                    state_next = lock_state(gnt_idx);
                end
            end
            LOCK_S0, LOCK_S1: begin
                if (handshake && sel_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_read_data_router.sv
// Directed self-checking bench for read_data_router: routing, stalls,
// round-robin contention, burst locking, unknown tags and reset.
module tb_read_data_router;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [7:0]  RID_S0, RID_S1;
    logic [31:0] RDATA_S0, RDATA_S1;
    logic [1:0]  RRESP_S0, RRESP_S1;
    logic        RLAST_S0, RLAST_S1;
    logic        RVALID_S0, RVALID_S1;
    logic        RREADY_S0, RREADY_S1;
    logic [3:0]  RID_M0, RID_M1;
    logic [31:0] RDATA_M0, RDATA_M1;
    logic [1:0]  RRESP_M0, RRESP_M1;
    logic        RLAST_M0, RLAST_M1;
    logic        RVALID_M0, RVALID_M1;
    logic        RREADY_M0, RREADY_M1;

    int checks = 0;
    int errors = 0;

    read_data_router dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .RID_S0    (RID_S0),
        .RDATA_S0  (RDATA_S0),
        .RRESP_S0  (RRESP_S0),
        .RLAST_S0  (RLAST_S0),
        .RVALID_S0 (RVALID_S0),
        .RREADY_S0 (RREADY_S0),
        .RID_S1    (RID_S1),
        .RDATA_S1  (RDATA_S1),
        .RRESP_S1  (RRESP_S1),
        .RLAST_S1  (RLAST_S1),
        .RVALID_S1 (RVALID_S1),
        .RREADY_S1 (RREADY_S1),
        .RID_M0    (RID_M0),
        .RDATA_M0  (RDATA_M0),
        .RRESP_M0  (RRESP_M0),
        .RLAST_M0  (RLAST_M0),
        .RVALID_M0 (RVALID_M0),
        .RREADY_M0 (RREADY_M0),
        .RID_M1    (RID_M1),
        .RDATA_M1  (RDATA_M1),
        .RRESP_M1  (RRESP_M1),
        .RLAST_M1  (RLAST_M1),
        .RVALID_M1 (RVALID_M1),
        .RREADY_M1 (RREADY_M1)
    );

    always #5 ACLK = ~ACLK;

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    task automatic drive_s0(input logic v, input logic [7:0] id, input logic [31:0] d,
                            input logic [1:0] r, input logic l);
        RVALID_S0 = v; RID_S0 = id; RDATA_S0 = d; RRESP_S0 = r; RLAST_S0 = l;
    endtask

    task automatic drive_s1(input logic v, input logic [7:0] id, input logic [31:0] d,
                            input logic [1:0] r, input logic l);
        RVALID_S1 = v; RID_S1 = id; RDATA_S1 = d; RRESP_S1 = r; RLAST_S1 = l;
    endtask

    task automatic clear_inputs;
        drive_s0(1'b0, 8'h00, 32'h0, 2'b00, 1'b0);
        drive_s1(1'b0, 8'h00, 32'h0, 2'b00, 1'b0);
        RREADY_M0 = 1'b0;
        RREADY_M1 = 1'b0;
    endtask

    task automatic reset_dut;
        ARESET = 1'b1;
        clear_inputs();
        tick();
        tick();
        ARESET = 1'b0;
    endtask

    task automatic test_reset;
        ARESET = 1'b1;
        drive_s0(1'b1, 8'h00, 32'h11111111, 2'b01, 1'b1);
        RREADY_M0 = 1'b1;
        #1;
        checks++;
        if ({RVALID_M0, RVALID_M1, RREADY_S0, RREADY_S1} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_handshake: got %b expected 0000",
                     {RVALID_M0, RVALID_M1, RREADY_S0, RREADY_S1});
        end
        checks++;
        if ({RID_M0, RDATA_M0, RRESP_M0, RLAST_M0} !== 39'h0) begin
            errors++;
            $display("FAIL reset_data_m0: got %h expected 0",
                     {RID_M0, RDATA_M0, RRESP_M0, RLAST_M0});
        end
        tick();
        ARESET = 1'b0;
        clear_inputs();
        #1;
        checks++;
        if ({RVALID_M0, RVALID_M1, RREADY_S0, RREADY_S1} !== 4'b0000) begin
            errors++;
            $display("FAIL idle_after_reset: got %b expected 0000",
                     {RVALID_M0, RVALID_M1, RREADY_S0, RREADY_S1});
        end
    endtask

    task automatic test_single_beat;
        clear_inputs();
        drive_s0(1'b1, 8'h12, 32'hDEADBEEF, 2'b00, 1'b1);
        RREADY_M1 = 1'b1;
        #1;
        checks++;
        if ({RVALID_M1, RID_M1, RDATA_M1, RLAST_M1, RREADY_S0, RVALID_M0} !==
            {1'b1, 4'h2, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL single_beat: got v=%b id=%h d=%h l=%b rdy_s0=%b v_m0=%b",
                     RVALID_M1, RID_M1, RDATA_M1, RLAST_M1, RREADY_S0, RVALID_M0);
        end
        tick();
        clear_inputs();
        // rr_ptr is now 1: a tie must go to S1
        drive_s0(1'b1, 8'h01, 32'h000000A0, 2'b00, 1'b1);
        drive_s1(1'b1, 8'h03, 32'h000000B0, 2'b10, 1'b1);
        #1;
        checks++;
        if ({RVALID_M0, RID_M0, RDATA_M0, RRESP_M0, RREADY_S0, RREADY_S1} !==
            {1'b1, 4'h3, 32'h000000B0, 2'b10, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL tie_after_single: got v=%b id=%h d=%h resp=%b rdy0=%b rdy1=%b expected S1 routed",
                     RVALID_M0, RID_M0, RDATA_M0, RRESP_M0, RREADY_S0, RREADY_S1);
        end
        tick();
        RREADY_M0 = 1'b1;
        #1;
        checks++;
        if ({RREADY_S1, RREADY_S0, RID_M0} !== {1'b1, 1'b0, 4'h3}) begin
            errors++;
            $display("FAIL tie_complete: got rdy1=%b rdy0=%b id=%h expected 1 0 3",
                     RREADY_S1, RREADY_S0, RID_M0);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_stall;
        clear_inputs();
        drive_s1(1'b1, 8'h05, 32'hCAFE0005, 2'b00, 1'b1);
        for (int c = 0; c < 4; c++) begin
            if (c == 1) drive_s0(1'b1, 8'h00, 32'h00000005, 2'b00, 1'b1);
            if (c == 3) RREADY_M0 = 1'b1;
            #1;
            checks++;
            if ({RVALID_M0, RID_M0, RDATA_M0, RLAST_M0, RREADY_S0, RREADY_S1} !==
                {1'b1, 4'h5, 32'hCAFE0005, 1'b1, 1'b0, (c == 3)}) begin
                errors++;
                $display("FAIL stall_cycle%0d: got v=%b id=%h d=%h l=%b rdy0=%b rdy1=%b",
                         c, RVALID_M0, RID_M0, RDATA_M0, RLAST_M0, RREADY_S0, RREADY_S1);
            end
            tick();
        end
        drive_s1(1'b0, 8'h00, 32'h0, 2'b00, 1'b0);
        #1;
        checks++;
        if ({RVALID_M0, RID_M0, RDATA_M0, RREADY_S0} !== {1'b1, 4'h0, 32'h00000005, 1'b1}) begin
            errors++;
            $display("FAIL stall_s0_after: got v=%b id=%h d=%h rdy0=%b expected 1 0 5 1",
                     RVALID_M0, RID_M0, RDATA_M0, RREADY_S0);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_contention;
        logic [31:0] exp_d;
        reset_dut();
        RREADY_M0 = 1'b1;
        RREADY_M1 = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c < 4) drive_s0(1'b1, 8'h0A, 32'h100 + 32'(c), 2'b00, (c == 3));
            else       drive_s0(1'b0, 8'h00, 32'h0, 2'b00, 1'b0);
            drive_s1(1'b1, 8'h1B, 32'h200 + 32'((c < 4) ? 0 : c - 4), 2'b01, (c == 7));
            #1;
            checks++;
            if (c < 4) begin
                exp_d = 32'h100 + 32'(c);
                if ({RVALID_M0, RID_M0, RDATA_M0, RLAST_M0, RREADY_S0, RREADY_S1, RVALID_M1} !==
                    {1'b1, 4'hA, exp_d, (c == 3), 1'b1, 1'b0, 1'b0}) begin
                    errors++;
                    $display("FAIL contention_s0_beat%0d: got v=%b id=%h d=%h l=%b rdy0=%b rdy1=%b v1=%b expected d=%h",
                             c, RVALID_M0, RID_M0, RDATA_M0, RLAST_M0, RREADY_S0, RREADY_S1, RVALID_M1, exp_d);
                end
            end else begin
                exp_d = 32'h200 + 32'(c - 4);
                if ({RVALID_M1, RID_M1, RDATA_M1, RRESP_M1, RLAST_M1, RREADY_S1, RREADY_S0, RVALID_M0} !==
                    {1'b1, 4'hB, exp_d, 2'b01, (c == 7), 1'b1, 1'b0, 1'b0}) begin
                    errors++;
                    $display("FAIL contention_s1_beat%0d: got v=%b id=%h d=%h resp=%b l=%b rdy1=%b rdy0=%b v0=%b expected d=%h",
                             c - 4, RVALID_M1, RID_M1, RDATA_M1, RRESP_M1, RLAST_M1, RREADY_S1, RREADY_S0, RVALID_M0, exp_d);
                end
            end
            tick();
        end
        drive_s0(1'b1, 8'h0C, 32'h300, 2'b00, 1'b1);
        drive_s1(1'b1, 8'h1D, 32'h400, 2'b00, 1'b1);
        #1;
        checks++;
        if ({RVALID_M0, RDATA_M0, RREADY_S0, RREADY_S1, RVALID_M1} !==
            {1'b1, 32'h300, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL contention_next_tie: got v0=%b d=%h rdy0=%b rdy1=%b v1=%b expected S0 wins",
                     RVALID_M0, RDATA_M0, RREADY_S0, RREADY_S1, RVALID_M1);
        end
        tick();
        drive_s0(1'b0, 8'h00, 32'h0, 2'b00, 1'b0);
        #1;
        checks++;
        if ({RVALID_M1, RDATA_M1, RREADY_S1} !== {1'b1, 32'h400, 1'b1}) begin
            errors++;
            $display("FAIL contention_s1_follow: got v1=%b d=%h rdy1=%b expected 1 400 1",
                     RVALID_M1, RDATA_M1, RREADY_S1);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_locked_gap;
        logic v;
        int   b;
        clear_inputs();
        RREADY_M0 = 1'b1;
        RREADY_M1 = 1'b1;
        drive_s1(1'b1, 8'h14, 32'h500, 2'b00, 1'b1);
        for (int c = 0; c < 6; c++) begin
            v = (c != 2) && (c != 3);
            b = (c < 2) ? c : c - 2;
            drive_s0(v, 8'h03, 32'h600 + 32'(b), 2'b00, v && (b == 3));
            #1;
            checks++;
            if ({RVALID_M0, RREADY_S1, RVALID_M1} !== {v, 1'b0, 1'b0} ||
                (v && RDATA_M0 !== 32'h600 + 32'(b))) begin
                errors++;
                $display("FAIL locked_gap_cycle%0d: got v0=%b d=%h rdy1=%b v1=%b expected v0=%b",
                         c, RVALID_M0, RDATA_M0, RREADY_S1, RVALID_M1, v);
            end
            tick();
        end
        drive_s0(1'b0, 8'h00, 32'h0, 2'b00, 1'b0);
        #1;
        checks++;
        if ({RVALID_M1, RID_M1, RDATA_M1, RREADY_S1} !== {1'b1, 4'h4, 32'h500, 1'b1}) begin
            errors++;
            $display("FAIL locked_gap_s1_grant: got v1=%b id=%h d=%h rdy1=%b expected 1 4 500 1",
                     RVALID_M1, RID_M1, RDATA_M1, RREADY_S1);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_unknown_tag;
        clear_inputs();
        drive_s1(1'b1, 8'h75, 32'h777, 2'b00, 1'b1);
        #1;
        checks++;
        if ({RREADY_S1, RVALID_M0, RVALID_M1} !== 3'b100) begin
            errors++;
            $display("FAIL unknown_tag_sink: got rdy1=%b v0=%b v1=%b expected 1 0 0",
                     RREADY_S1, RVALID_M0, RVALID_M1);
        end
        checks++;
        if ({RDATA_M0, RDATA_M1} !== 64'h0) begin
            errors++;
            $display("FAIL unknown_tag_data: got d0=%h d1=%h expected 0 0", RDATA_M0, RDATA_M1);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (RREADY_S1 !== 1'b0) begin
            errors++;
            $display("FAIL unknown_tag_release: got rdy1=%b expected 0", RREADY_S1);
        end
    endtask

    task automatic test_reset_mid_burst;
        clear_inputs();
        RREADY_M1 = 1'b1;
        for (int c = 0; c < 2; c++) begin
            drive_s1(1'b1, 8'h11, 32'h800 + 32'(c), 2'b00, 1'b0);
            #1;
            checks++;
            if ({RVALID_M1, RDATA_M1} !== {1'b1, 32'h800 + 32'(c)}) begin
                errors++;
                $display("FAIL rst_burst_beat%0d: got v1=%b d=%h", c, RVALID_M1, RDATA_M1);
            end
            tick();
        end
        drive_s1(1'b1, 8'h11, 32'h802, 2'b00, 1'b0);
        ARESET = 1'b1;
        #1;
        checks++;
        if ({RVALID_M0, RVALID_M1, RREADY_S0, RREADY_S1, RID_M1, RDATA_M1, RRESP_M1, RLAST_M1} !== 43'h0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got v0=%b v1=%b rdy0=%b rdy1=%b id=%h d=%h expected all 0",
                     RVALID_M0, RVALID_M1, RREADY_S0, RREADY_S1, RID_M1, RDATA_M1);
        end
        tick();
        ARESET = 1'b0;
        drive_s0(1'b1, 8'h01, 32'h900, 2'b00, 1'b1);
        RREADY_M0 = 1'b1;
        #1;
        checks++;
        if ({RVALID_M0, RID_M0, RDATA_M0, RREADY_S0, RREADY_S1, RVALID_M1} !==
            {1'b1, 4'h1, 32'h900, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rst_first_grant: got v0=%b id=%h d=%h rdy0=%b rdy1=%b v1=%b expected S0 granted",
                     RVALID_M0, RID_M0, RDATA_M0, RREADY_S0, RREADY_S1, RVALID_M1);
        end
        tick();
        clear_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ARESET = 1'b1;
        clear_inputs();
        tick();
        tick();
        test_reset();
        test_single_beat();
        test_stall();
        test_contention();
        test_locked_gap();
        test_unknown_tag();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
